// File: rtl/prog_minterm_lut.sv
// prog_minterm_lut: run-time programmable N-input boolean function, one-hot minterm decode
// ORed through a truth table that is shifted into a shadow register and committed atomically.
module prog_minterm_lut #(
    parameter  int N     = 4,
    localparam int DEPTH = 1 << N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    input  logic             in_valid,
    input  logic [N-1:0]     in,
    output logic             busy,
    output logic             loaded,
    output logic             out_valid,
    output logic             f,
    output logic [DEPTH-1:0] dec
);
    typedef enum logic {IDLE, LOAD} state_t;
    state_t           state;
    logic [N:0]       cnt;
    logic [DEPTH-1:0] shadow, shadow_nxt, act_tbl;
    logic             last_bit;

    assign busy     = state == LOAD;
    assign last_bit = cnt == (N+1)'(DEPTH - 1);

    // shadow including the bit being accepted this cycle, so the commit sees the full table
    always_comb begin
        shadow_nxt = shadow;
        shadow_nxt[cnt[N-1:0]] = cfg_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            act_tbl   <= '0;
            loaded    <= 1'b0;
            out_valid <= 1'b0;
            f         <= 1'b0;
            dec       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                f   <= act_tbl[in];
                dec <= DEPTH'(1) << in;
            end
            if (state == IDLE) begin
                if (load_start) begin
                    state  <= LOAD;
                    cnt    <= '0;
                    shadow <= '0;
                end
            end else if (load_start) begin
                cnt    <= '0;
                shadow <= '0;
            end else if (cfg_valid) begin
                shadow <= shadow_nxt;
                cnt    <= last_bit ? '0 : cnt + 1'b1;
                if (last_bit) begin
                    act_tbl <= shadow_nxt;
                    loaded  <= 1'b1;
                    state   <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_prog_minterm_lut.sv
// tb_prog_minterm_lut: scoreboard bench for N=1, N=4 and N=8 builds of prog_minterm_lut;
// expectations are queued at the sampling edge and popped by per-instance monitors.
module tb_prog_minterm_lut;
    logic         clk = 1'b0, rst_n = 1'b0, ld = 1'b0, cv = 1'b0, cb = 1'b0;
    logic         iv1 = 1'b0, iv4 = 1'b0, iv8 = 1'b0;
    logic [7:0]   in = '0;
    logic         busy1, loaded1, ov1, f1;
    logic         busy4, loaded4, ov4, f4;
    logic         busy8, loaded8, ov8, f8;
    logic [1:0]   dec1;
    logic [15:0]  dec4;
    logic [255:0] dec8;
    logic [15:0]  tbl_a = 16'h9CFC, tbl_b = 16'h0001;

    typedef struct {logic f; logic [7:0] idx;} exp_t;
    exp_t q1[$], q4[$], q8[$];
    exp_t e1, e4, e8;
    int   checks = 0, passes = 0;

    prog_minterm_lut #(.N(1)) d1 (.clk(clk), .rst_n(rst_n), .load_start(ld), .cfg_valid(cv), .cfg_bit(cb),
        .in_valid(iv1), .in(in[0:0]), .busy(busy1), .loaded(loaded1), .out_valid(ov1), .f(f1), .dec(dec1));
    prog_minterm_lut #(.N(4)) d4 (.clk(clk), .rst_n(rst_n), .load_start(ld), .cfg_valid(cv), .cfg_bit(cb),
        .in_valid(iv4), .in(in[3:0]), .busy(busy4), .loaded(loaded4), .out_valid(ov4), .f(f4), .dec(dec4));
    prog_minterm_lut #(.N(8)) d8 (.clk(clk), .rst_n(rst_n), .load_start(ld), .cfg_valid(cv), .cfg_bit(cb),
        .in_valid(iv8), .in(in), .busy(busy8), .loaded(loaded8), .out_valid(ov8), .f(f8), .dec(dec8));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // sel picks which instance evaluates this cycle (0 = none); ef is the hand-computed f
    task automatic step(input logic l, input logic c, input logic b, input int sel,
                        input logic [7:0] x, input logic ef);
        ld = l; cv = c; cb = b; in = x;
        iv1 = sel == 1; iv4 = sel == 4; iv8 = sel == 8;
        @(posedge clk);
        if (sel == 1) q1.push_back('{ef, x});
        if (sel == 4) q4.push_back('{ef, x});
        if (sel == 8) q8.push_back('{ef, x});
        #1;
    endtask

    always @(negedge clk) if (rst_n && (ov4 || q4.size() > 0)) begin
        if (ov4 && q4.size() > 0) begin
            e4 = q4.pop_front();
            chk("f4", f4, e4.f);
            chk("dec4", dec4, 16'(1) << e4.idx[3:0]);
        end else begin
            chk("out_valid4", ov4, q4.size() > 0);
            if (q4.size() > 0) q4.delete(0);
        end
    end

    always @(negedge clk) if (rst_n && (ov1 || q1.size() > 0)) begin
        if (ov1 && q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("f1", f1, e1.f);
            chk("dec1", dec1, 2'(1) << e1.idx[0]);
        end else begin
            chk("out_valid1", ov1, q1.size() > 0);
            if (q1.size() > 0) q1.delete(0);
        end
    end

    always @(negedge clk) if (rst_n && (ov8 || q8.size() > 0)) begin
        if (ov8 && q8.size() > 0) begin
            e8 = q8.pop_front();
            chk("f8", f8, e8.f);
            chk("dec8", dec8, 256'(1) << e8.idx);
        end else begin
            chk("out_valid8", ov8, q8.size() > 0);
            if (q8.size() > 0) q8.delete(0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        iv4 = 1'b1; in = 8'd5;
        #12;
        chk("rst out_valid", ov4, 0);
        chk("rst f", f4, 0);
        chk("rst dec", dec4, 0);
        chk("rst busy", busy4, 0);
        chk("rst loaded", loaded4, 0);
        iv4 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 0, 4, 5, 0);
        // load_start with cfg_valid in IDLE: that bit must be discarded
        step(1, 1, 1, 0, 0, 0);
        chk("busy after start", busy4, 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, tbl_a[i], 0, 0, 0);
            if (i == 14) begin
                chk("loaded before last bit", loaded4, 0);
                chk("busy before last bit", busy4, 1);
            end
        end
        chk("loaded after commit", loaded4, 1);
        chk("busy after commit", busy4, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 4, 8'(i), tbl_a[i]);
        step(0, 0, 0, 0, 0, 0);
        chk("hold out_valid", ov4, 0);
        chk("hold f", f4, 1);
        chk("hold dec", dec4, 16'h8000);
        // reload 0x0001 while evaluating in=2; old table stays live through the commit edge
        step(1, 0, 0, 4, 2, 1);
        for (int i = 0; i < 16; i++) step(0, 1, tbl_b[i], 4, 2, 1);
        step(0, 0, 0, 4, 2, 0);
        step(0, 0, 0, 4, 0, 1);
        // gapped load, then abort and a full load of ones
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 4, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4, 0, 1);
        step(1, 1, 0, 4, 3, 0);
        chk("busy after abort", busy4, 1);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 4, 5, 0);
        chk("loaded after ffff", loaded4, 1);
        chk("busy after ffff", busy4, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 4, 8'(i), 1);
        // commit 0x9CFC, then reset part-way through another load
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, tbl_a[i], 0, 0, 0);
        step(1, 0, 0, 4, 3, 1);
        for (int i = 0; i < 6; i++) step(0, 1, tbl_a[i], 4, 3, 1);
        step(0, 1, tbl_a[6], 0, 0, 0);
        chk("busy mid-load", busy4, 1);
        chk("f before reset", f4, 1);
        rst_n = 1'b0;
        #1;
        chk("async rst busy", busy4, 0);
        chk("async rst loaded", loaded4, 0);
        chk("async rst out_valid", ov4, 0);
        chk("async rst f", f4, 0);
        chk("async rst dec", dec4, 0);
        cv = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 0, 4, 3, 0);
        chk("loaded after rst", loaded4, 0);
        // N=1 build: table 0b10 gives f = in
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        chk("loaded1", loaded1, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        // N=8 build: only minterm 255 set
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) step(0, 1, i == 255, 0, 0, 0);
        chk("loaded8", loaded8, 1);
        step(0, 0, 0, 8, 0, 0);
        step(0, 0, 0, 8, 1, 0);
        step(0, 0, 0, 8, 128, 0);
        step(0, 0, 0, 8, 254, 0);
        step(0, 0, 0, 8, 255, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("q4 drained", q4.size(), 0);
        chk("q1 drained", q1.size(), 0);
        chk("q8 drained", q8.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
